// File: rtl/down_counter_timer_pkg.sv
// Shared types and constants for the down-counting timer.
package down_counter_timer_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_e;

endpackage

// File: rtl/down_counter_timer_dcnt_cell.sv
// One bit of the registered decrementer: synchronous reset, parallel load,
// borrow-chained decrement, otherwise hold.
module dcnt_cell (
  input  logic clk,
  input  logic reset,
  input  logic ld,
  input  logic d,
  input  logic dec_en,
  input  logic borrow_in,
  output logic q,
  output logic borrow_out
);

  // A bit borrows onward only when it is already 0 and must flip to 1.
  assign borrow_out = borrow_in & ~q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 1'b0;
    end else if (ld) begin
      q <= d;
    end else if (dec_en) begin
      q <= q ^ borrow_in;
    end
  end

endmodule

// File: rtl/down_counter_timer.sv
// Down-counting timer with load, start, level pause, terminal-count pulse and
// optional auto-reload from the last loaded value.
module down_counter_timer
  import down_counter_timer_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             zero,
  output logic             done
);

  state_e           state, state_next;
  logic [WIDTH-1:0] reload_reg;
  logic             done_next;
  logic             dec;
  logic             reload;
  logic             cell_ld;
  logic [WIDTH-1:0] cell_d;
  logic [WIDTH:0]   borrow;

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    dec        = 1'b0;
    reload     = 1'b0;
    if (!load) begin
      unique case (state)
        IDLE: begin
          if (start) begin
            if (q != '0) state_next = RUN;
            else         done_next  = 1'b1;
          end
        end
        RUN: begin
          if (pause) begin
            state_next = PAUSED;
          end else if (q == '0) begin
            state_next = IDLE;
          end else begin
            dec = 1'b1;
            if (q == WIDTH'(1)) begin
              done_next = 1'b1;
              // A zero reload value would spin forever at zero; treat as one-shot.
              if (AUTO_RELOAD && reload_reg != '0) reload     = 1'b1;
              else                                 state_next = IDLE;
            end
          end
        end
        PAUSED: begin
          if (!pause) state_next = RUN;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      reload_reg <= '0;
      done       <= 1'b0;
    end else begin
      state <= load ? IDLE : state_next;
      done  <= done_next;
      if (load) reload_reg <= load_val;
    end
  end

  assign cell_ld   = load | reload;
  assign cell_d    = load ? load_val : reload_reg;
  assign borrow[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dcnt_cell u_cell (
      .clk       (clk),
      .reset     (reset),
      .ld        (cell_ld),
      .d         (cell_d[i]),
      .dec_en    (dec),
      .borrow_in (borrow[i]),
      .q         (q[i]),
      .borrow_out(borrow[i+1])
    );
  end

  assign busy = (state != IDLE);
  assign zero = (q == '0);

endmodule

// File: doc/down_counter_timer.md
DOWN_COUNTER_TIMER -- requirements
Module: down_counter_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter width in bits (legal range 2..16).
REQ-002 SHALL have parameter AUTO_RELOAD, default 0; 1 reloads the last loaded value on terminal count.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port load  input  1  load q and the reload register from load_val.
REQ-006 SHALL have port load_val  input  WIDTH  value to load.
REQ-007 SHALL have port start  input  1  begin counting down from current q.
REQ-008 SHALL have port pause  input  1  level; freeze count while high.
REQ-009 SHALL have port q  output  WIDTH  current count, registered.
REQ-010 SHALL have port busy  output  1  high in RUN or PAUSED.
REQ-011 SHALL have port zero  output  1  combinational (q == 0).
REQ-012 SHALL have port done  output  1  registered terminal-count pulse, exactly one cycle wide.

Function
REQ-013 SHALL implement states IDLE, RUN, PAUSED; busy = (state != IDLE).
REQ-014 SHALL apply priority per edge: reset > load > start > pause > decrement.
REQ-015 load on any edge: q and reload_reg <= load_val, state -> IDLE, done <= 0; in-progress count aborted.
REQ-016 start in IDLE with q != 0: state -> RUN, q unchanged on that edge.
REQ-017 start in IDLE with q == 0: state stays IDLE, done <= 1 next cycle (zero-length count).
REQ-018 start in RUN or PAUSED SHALL be ignored.
REQ-019 In RUN with pause low: q <= q - 1 each edge; N cycles from start edge to q == 0.
REQ-020 In RUN with pause high: q held, state -> PAUSED; in PAUSED with pause low: state -> RUN, q held on that edge.
REQ-021 Terminal edge (RUN, pause low, q == 1): done <= 1; AUTO_RELOAD=0: q <= 0, state -> IDLE; AUTO_RELOAD=1: q <= reload_reg, state stays RUN.
REQ-022 AUTO_RELOAD=1 with reload_reg == 0 SHALL behave as AUTO_RELOAD=0 (no infinite zero loop).
REQ-023 q SHALL never wrap below 0; arithmetic is unsigned modulo-free, WIDTH bits.
REQ-024 done SHALL be 0 on every edge other than those in REQ-017/REQ-021.

Reset
REQ-025 On reset edge: q = 0, reload_reg = 0, state = IDLE, busy = 0, done = 0; zero = 1 follows.
REQ-026 Reset asserted mid-count SHALL abort immediately, no done pulse; load/start same edge ignored.

Structure
REQ-027 Shared package SHALL hold the state enum (IDLE/RUN/PAUSED) and WIDTH default constant.
REQ-028 Single sub-module dcnt_cell SHALL implement one bit of the registered decrementer (borrow in/out, load, hold); instantiated WIDTH times via generate.
REQ-029 Next-state logic and done register SHALL live in the top module; no latches, no derived clocks.

Verification
REQ-030 WIDTH=4: reset, load 5, start, pause low -> q 5,4,3,2,1,0 on successive edges; done high one cycle with q==0; busy drops same edge.
REQ-031 load 6, start, pause high 3 cycles when q==4 -> q holds 4 for 3 cycles plus one resume cycle, then 3..0, single done pulse.
REQ-032 AUTO_RELOAD=1, load 3, start -> q 3,2,1,3,2,1,... done pulse at each reload, busy stays 1.
REQ-033 load 0, start -> done one cycle next edge, busy never 1; load 15 start -> 15 decrements, no wrap to 15 after 0.
REQ-034 Reset at q==2 during RUN -> q 0, busy 0, no done; load+start same edge -> q=load_val, state IDLE.
REQ-035 start asserted while RUN at q==7 -> ignored, count continues 6,5,...
